// File: rtl/spi_pkg.sv
// spi_pkg: frame geometry, master FSM states and frame builder shared by the SPI master
package spi_pkg;
  localparam int FRAME_W = 32;
  localparam int HDR_W = 16;
  localparam int RW_BIT = 31;
  localparam int ADDR_LSB = 16;
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} spi_mst_state_t;
  // Header is rw, zero pad, address; data phase follows
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic rw,
    input logic [HDR_W-2:0] addr,
    input logic [FRAME_W-HDR_W-1:0] data
  );
    return {rw, addr, data};
  endfunction
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period counter producing sclk and rise/fall ticks while enabled
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic shift,
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic half_done,
  output logic low_half
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic ph;
  assign half_done = en && cnt == CW'(CLK_DIV - 1);
  assign low_half = ph;
  assign sclk = shift && !ph;
  assign rise = shift && !ph && cnt == '0;
  assign fall = shift && ph && cnt == '0;
  // Count clk cycles within a half period; phase flips high->low->high each half
  always_ff @(posedge clk) begin
    if (reset || clr || !en) begin
      cnt <= '0;
      ph <= 1'b0;
    end else if (half_done) begin
      cnt <= '0;
      ph <= ~ph;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master serialising one 32-bit register transaction per request
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int CS_IDLE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic busy,
  output logic sclk,
  output logic mosi,
  input  logic miso,
  output logic cs
);
  localparam int GW = CS_IDLE > 1 ? $clog2(CS_IDLE) : 1;
  if (CLK_DIV < 2) begin : g_bad_div
    $error("spi_master: CLK_DIV must be >= 2");
  end
  if (CS_IDLE < 1) begin : g_bad_gap
    $error("spi_master: CS_IDLE must be >= 1");
  end
  if (ADDR_W > HDR_W - 1) begin : g_bad_addr
    $error("spi_master: ADDR_W does not fit the header");
  end
  spi_mst_state_t state, state_n;
  logic [FRAME_W-1:0] frame_q;
  logic [DATA_W-1:0] rx_q;
  logic rw_q;
  logic [4:0] bit_q;
  logic [GW-1:0] gap_q;
  logic accept, run, clr, rise, fall, half_done, low_half;
  assign run = state == LEAD || state == SHIFT || state == TRAIL;
  assign clr = state_n != state;
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk(clk),
    .reset(reset),
    .en(run),
    .clr(clr),
    .shift(state == SHIFT),
    .sclk(sclk),
    .rise(rise),
    .fall(fall),
    .half_done(half_done),
    .low_half(low_half)
  );
  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // Next state and frame-level outputs
  always_comb begin
    state_n = state;
    req_ready = state == IDLE && !reset;
    accept = req_valid && req_ready;
    busy = state != IDLE;
    cs = !run;
    mosi = run ? frame_q[RW_BIT] : 1'b0;
    case (state)
      IDLE:  if (accept) state_n = LEAD;
      LEAD:  if (half_done) state_n = SHIFT;
      SHIFT: if (half_done && !low_half && bit_q == 5'd31) state_n = TRAIL;
      TRAIL: if (half_done) state_n = GAP;
      GAP:   if (gap_q == GW'(CS_IDLE - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Frame capture, MOSI/MISO shifting, bit and gap counting, response
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
      rx_q <= '0;
      rw_q <= 1'b0;
      bit_q <= '0;
      gap_q <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= state == TRAIL && half_done;
      if (accept) begin
        frame_q <= build_frame(req_write, (HDR_W-1)'(req_addr),
                               req_write ? (FRAME_W-HDR_W)'(req_wdata) : '0);
        rw_q <= req_write;
        bit_q <= '0;
      end else if (fall) begin
        frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
      end
      if (rise) rx_q <= {rx_q[DATA_W-2:0], miso};
      if (state == SHIFT && half_done && low_half) bit_q <= bit_q + 5'd1;
      gap_q <= state == GAP ? gap_q + GW'(1) : '0;
      if (state == TRAIL && half_done) rsp_rdata <= rw_q ? '0 : rx_q;
    end
  end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI mode-0 master that issues single-word register transactions to the accelerator's SPI slave, which sits at the other end of the link. It is used as the on-FPGA/bench-side initiator for loopback bring-up, and in place of the STM32 host.
A simple valid/ready request port is serialised into one 32-bit CS-framed transfer: a 16-bit header followed by a 16-bit data phase. The read data captured on MISO is returned on a response pulse.

Parameters:
CLK_DIV, 4, sclk half-period in clk cycles; must be >= 2, checked at elaboration.
ADDR_W, 10, address width; matches the accelerator's 10-bit memory/CSR address space.
DATA_W, 16, data word width.
CS_IDLE, 4, minimum clk cycles cs stays high between frames.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  transaction request
req_ready  output  1  high only in IDLE; a transfer is accepted on req_valid && req_ready
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  target address
req_wdata  input  DATA_W  write data; ignored for reads
rsp_valid  output  1  one-cycle pulse when a frame completes
rsp_rdata  output  DATA_W  captured MISO data phase; 0 for writes
busy  output  1  high from accept until return to IDLE
sclk  output  1  SPI clock, idle low
mosi  output  1  SPI data out, MSB first
miso  input  1  SPI data in
cs  output  1  chip select, active low

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values: cs=1, sclk=0, mosi=0, req_ready=0 while reset is high, rsp_valid=0, rsp_rdata=0, busy=0, state=IDLE.
- Frame layout, 32 bits, MSB first:
  - [31] rw
  - [30:26] 0
  - [25:16] addr
  - [15:0] wdata for writes, 0 for reads.
- Request capture: on accept, the frame, rw flag and address are registered. Request inputs are don't-care afterwards.
- FSM IDLE -> LEAD -> SHIFT -> TRAIL -> GAP -> IDLE.
  - IDLE: req_ready=1. On accept go to LEAD; cs=0 and mosi=bit31 from the next cycle.
  - LEAD: sclk=0 for CLK_DIV cycles (setup half-period).
  - SHIFT: 32 bits, each a high half then a low half of CLK_DIV cycles each. The 32nd low half is the TRAIL state.
  - SHIFT edges: sclk rises at the start of each high half. miso is sampled in the first cycle of each high half. mosi updates to the next bit at the start of each low half.
  - TRAIL: sclk=0 and mosi holds bit0 for CLK_DIV cycles.
  - TRAIL exit: cs=1 and rsp_valid=1 for exactly one cycle, then GAP.
  - GAP: cs=1 for CS_IDLE cycles, then IDLE.
- Timing with accept at cycle 0:
  - cs low for cycles 1 .. 65*CLK_DIV.
  - rsp_valid at cycle 65*CLK_DIV+1.
  - req_ready at cycle 65*CLK_DIV+1+CS_IDLE.
- MISO capture: the 32 sampled bits shift into a register. Only bits 15:0 (the data phase) are loaded to rsp_rdata, and only for reads.
  - For writes, rsp_rdata=0.
  - rsp_rdata holds until the next rsp_valid.
- req_valid while busy: ignored, not queued. The requester must hold req_valid until req_ready.
- Reset mid-frame: on the next edge cs=1, sclk=0, mosi=0, state=IDLE, no rsp_valid. A partial frame is not resumed.
- A half-period counter runs only outside IDLE/GAP. It is cleared on accept and on every state change.

Decomposition:
- spi_pkg:
  - FRAME_W=32, HDR_W=16, RW_BIT=31
  - ADDR_LSB=16
  - typedef enum spi_mst_state_t {IDLE, LEAD, SHIFT, TRAIL, GAP}
- Sub-module spi_clk_gen: half-period counter producing sclk and the rise/fall tick pulses, enabled by the FSM.

Test Plan:
- Write, CLK_DIV=4: addr=0x155, wdata=0xA5C3.
  - MOSI bits captured on sclk rises = 0x8155A5C3.
  - cs low for exactly 260 cycles, rsp_valid at cycle 261, rsp_rdata=0.
- Read: addr=0x3FF, a slave model drives 0x1234 in the data phase.
  - MOSI header = 0x03FF, data phase zeros.
  - rsp_rdata=0x1234 with a single rsp_valid pulse.
- Back-to-back: req_valid held high for 3 writes.
  - Exactly 3 frames, separated by >= CS_IDLE cs-high cycles.
  - Exactly 3 rsp_valid pulses.
  - req_ready low throughout each frame.
- Reset mid-frame: assert reset at bit 10 of a write.
  - Next cycle cs=1, sclk=0, mosi=0, no rsp_valid.
  - A following read completes normally.
- CLK_DIV=2: sclk period = 4 clk cycles.
  - Frame = 130 cycles of cs low; read data still captured correctly.
- Loopback with the accelerator's spi_slave: write 0x000F to the vector CSR address, then read it back.
  - Read returns 0x000F; led shows 4'hF.
